uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUDRATE, default 5208, meaning clock cycles per bit period (9600 baud at 50 MHz); legal range 4..65535.
REQ-002 SHALL have port clk, input, 1, system clock; all logic is on the rising edge of clk.
REQ-003 SHALL have port rst, input, 1, reset; the reset is synchronous and active-high.
REQ-004 SHALL have port rx, input, 1, serial data input; asynchronous to clk; idles high.
REQ-005 SHALL have port data, output, 8, last correctly framed received byte.
REQ-006 SHALL have port rcv, output, 1, one-cycle strobe: data has just been updated.
REQ-007 SHALL have port ferr, output, 1, one-cycle strobe: framing error (stop bit sampled 0).
REQ-008 SHALL have port busy, output, 1, high while a frame is in progress (any state other than IDLE).

Function
REQ-009 SHALL synchronise rx through a 2-flop synchroniser; all decisions use the synchronised signal rxs, never raw rx.
REQ-010 SHALL accept the frame format 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 SHALL implement the states IDLE, START, DATA, STOP and BREAK.
REQ-012 IDLE: on rxs==0, SHALL go to START, clear the bit counter, and load the baud counter for a half bit period (BAUDRATE/2, truncated).
REQ-013 START: when the half period expires, SHALL sample rxs; if 0, go to DATA and load a full period; if 1 (glitch/false start), return to IDLE with no strobe.
REQ-014 DATA: at each full-period expiry, SHALL shift rxs into bit 7 of an 8-bit shift register (shift right); after the 8th sample, go to STOP and load a full period.
REQ-015 STOP, stop sample==1: SHALL load the shift register into data, pulse rcv for exactly 1 cycle, and go to IDLE.
REQ-016 STOP, stop sample==0: SHALL pulse ferr for exactly 1 cycle, leave data unchanged, and go to BREAK.
REQ-017 BREAK: SHALL stay until rxs==1, then go to IDLE; no strobes in BREAK.
REQ-018 Sample timing: the nth sample (n=0 start … 9 stop) SHALL occur BAUDRATE/2 + n*BAUDRATE cycles after the cycle in which IDLE saw rxs==0.
REQ-019 Latency: rcv/ferr SHALL be registered, asserting on the cycle after the stop sample.
REQ-020 data SHALL hold its value until the next good frame; it may be read at any time after rcv.
REQ-021 rcv and ferr SHALL never be high in the same cycle, and each SHALL never be high for 2 consecutive cycles.
REQ-022 Back-to-back: a start edge arriving on the first IDLE cycle after STOP SHALL be accepted with no lost frame.
REQ-023 The baud counter SHALL be sized to ceil(log2(BAUDRATE)) bits and SHALL NOT wrap inside a period.
REQ-024 busy SHALL be high from the cycle after the start edge is seen through the cycle the state returns to IDLE.

Reset
REQ-025 When rst==1 at a clock edge, SHALL set state=IDLE, the synchroniser flops=1, the counters=0, the shift register=0, data=8'h00, rcv=0, ferr=0 and busy=0.
REQ-026 Reset mid-frame SHALL abandon the frame with no rcv/ferr strobe; after release, reception restarts on the next falling edge.
REQ-027 rst SHALL take priority over all other activity in the same cycle.

Verification (BAUDRATE=16 for the bench)
REQ-028 Frame 0x41 ('A') sent at exactly 16 cycles/bit -> rcv pulses once, data==8'h41, ferr stays 0.
REQ-029 rx low for 4 cycles, then high -> no rcv, no ferr, busy returns to 0 by cycle 8 + synchroniser delay.
REQ-030 Frame 0x55 with stop bit=0, rx then held low for 40 cycles -> ferr pulses once, data keeps its prior value, busy stays high until rx rises.
REQ-031 Frames 0x00, 0xFF and 0xA5 sent back-to-back with no idle gap -> 3 rcv pulses with data 00, FF, A5 in order.
REQ-032 rst asserted for 1 cycle during bit 4 of a frame -> no strobe; the following frame 0x3C is received correctly.
REQ-033 Frame 0x96 sent at ±3% bit-rate error (15.5/16.5 cycles/bit) -> data==8'h96, no ferr.

Source files
------------

// File: rtl/uart_rx_if.sv
// Signal bundle for the UART receiver: serial line in, received byte and
// status strobes out.
interface uart_rx_if;
   logic       rx;     // serial data line, idles high, asynchronous to clk
   logic [7:0] data;   // last correctly framed byte
   logic       rcv;    // one-cycle strobe: data just updated
   logic       ferr;   // one-cycle strobe: stop bit sampled low
   logic       busy;   // frame in progress

   // Side that drives the line and consumes the results
   modport master (
      output rx,
      input  data,
      input  rcv,
      input  ferr,
      input  busy
   );

   // The receiver itself
   modport slave (
      input  rx,
      output data,
      output rcv,
      output ferr,
      output busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, mid-bit sampling driven by a down-counting
// baud timer. BAUDRATE is the number of clk cycles per bit period.
module uart_rx #(
   parameter int unsigned BAUDRATE = 5208
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);

   // Counter just wide enough to hold BAUDRATE-1 (never wraps in a period)
   localparam int unsigned CW = $clog2(BAUDRATE);

   // Reload values: the counter expires one cycle after it reaches zero,
   // so loading N-1 yields a sample exactly N cycles after the load.
   localparam logic [CW-1:0] HALF_LD = CW'(BAUDRATE / 2 - 1);
   localparam logic [CW-1:0] FULL_LD = CW'(BAUDRATE - 1);

   // Receiver states
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] DATA  = 3'd2;
   localparam logic [2:0] STOP  = 3'd3;
   localparam logic [2:0] BREAK = 3'd4;

   logic          rx_meta;
   logic          rxs;
   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic [7:0]    data_q;
   logic          rcv_q;
   logic          ferr_q;
   logic          tick;

   // Baud timer has reached the sample point
   assign tick = (cnt == '0);

   // Two-flop synchroniser; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rxs     <= rx_meta;
      end
   end

   // Frame state machine with baud timer, bit counter and output strobes
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         bitcnt <= '0;
         shreg  <= '0;
         data_q <= '0;
         rcv_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         rcv_q  <= 1'b0;
         ferr_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!rxs) begin
                  state  <= START;
                  bitcnt <= '0;
                  cnt    <= HALF_LD;
               end
            end

            START: begin
               if (tick) begin
                  if (!rxs) begin
                     state <= DATA;
                     cnt   <= FULL_LD;
                  end else begin
                     // line went back high: false start, drop silently
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            DATA: begin
               if (tick) begin
                  shreg  <= {rxs, shreg[7:1]};
                  cnt    <= FULL_LD;
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            STOP: begin
               if (tick) begin
                  if (rxs) begin
                     data_q <= shreg;
                     rcv_q  <= 1'b1;
                     state  <= IDLE;
                  end else begin
                     ferr_q <= 1'b1;
                     state  <= BREAK;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end

            BREAK: begin
               // wait out a held-low line before looking for a new start
               if (rxs) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs
   assign bus.data = data_q;
   assign bus.rcv  = rcv_q;
   assign bus.ferr = ferr_q;
   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk cycles per bit.
module tb_uart_rx;
   localparam int unsigned BR     = 16;
   localparam int unsigned BIT_T  = 160;   // one bit period in time units (clk period 10)

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   uart_rx_if bus ();

   uart_rx #(.BAUDRATE(BR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc = 0;

   int unsigned rcv_cnt   = 0;
   int unsigned ferr_cnt  = 0;
   int unsigned rule_viol = 0;
   int unsigned rcv_cyc   = 0;
   logic        prev_rcv  = 1'b0;
   logic        prev_ferr = 1'b0;
   logic [7:0]  got[$];

   // cycle counter advanced on every active edge
   always @(posedge clk) cyc <= cyc + 1;

   // strobe monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (bus.rcv === 1'b1) begin
         rcv_cnt <= rcv_cnt + 1;
         rcv_cyc <= cyc;
         got.push_back(bus.data);
      end
      if (bus.ferr === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if ((bus.rcv && bus.ferr) || (bus.rcv && prev_rcv) || (bus.ferr && prev_ferr))
         rule_viol <= rule_viol + 1;
      prev_rcv  <= bus.rcv;
      prev_ferr <= bus.ferr;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stopb, input int unsigned bt);
      bus.rx = 1'b0;
      #(bt);
      for (int i = 0; i < 8; i++) begin
         bus.rx = b[i];
         #(bt);
      end
      bus.rx = stopb;
      #(bt);
   endtask

   task automatic settle(input int unsigned n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   int unsigned c0;
   int unsigned r0;
   int unsigned f0;
   int unsigned n0;

   initial begin
      bus.rx = 1'b1;
      rst    = 1'b1;

      // reset state
      settle(3);
      chk("reset_data", {24'h0, bus.data}, 32'h00);
      chk("reset_rcv",  {31'h0, bus.rcv},  32'h0);
      chk("reset_ferr", {31'h0, bus.ferr}, 32'h0);
      chk("reset_busy", {31'h0, bus.busy}, 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      settle(5);

      // clean frame 0x41, with stop-sample-to-strobe latency
      @(posedge clk);
      #1 c0 = cyc;
      send_frame(8'h41, 1'b1, BIT_T);
      settle(10);
      chk("a_rcv_count", rcv_cnt,  32'd1);
      chk("a_data",      {24'h0, bus.data}, 32'h41);
      chk("a_ferr",      ferr_cnt, 32'd0);
      chk("a_latency",   rcv_cyc - c0, 32'd155);

      // short low glitch: false start, no strobe
      r0 = rcv_cnt;
      f0 = ferr_cnt;
      @(posedge clk);
      #1 c0 = cyc;
      bus.rx = 1'b0;
      repeat (4) @(posedge clk);
      #1 bus.rx = 1'b1;
      settle(1);
      chk("glitch_busy_hi", {31'h0, bus.busy}, 32'h1);
      settle(7);
      chk("glitch_busy_lo", {31'h0, bus.busy}, 32'h0);
      settle(20);
      chk("glitch_rcv",  rcv_cnt,  r0);
      chk("glitch_ferr", ferr_cnt, f0);

      // framing error: stop bit low, line held low afterwards
      r0 = rcv_cnt;
      f0 = ferr_cnt;
      send_frame(8'h55, 1'b0, BIT_T);
      settle(40);
      chk("ferr_busy_hi", {31'h0, bus.busy}, 32'h1);
      chk("ferr_count",   ferr_cnt, f0 + 1);
      chk("ferr_rcv",     rcv_cnt,  r0);
      chk("ferr_data",    {24'h0, bus.data}, 32'h41);
      bus.rx = 1'b1;
      settle(5);
      chk("ferr_busy_lo", {31'h0, bus.busy}, 32'h0);
      settle(10);

      // back-to-back frames with no idle gap
      r0 = rcv_cnt;
      n0 = got.size();
      send_frame(8'h00, 1'b1, BIT_T);
      send_frame(8'hFF, 1'b1, BIT_T);
      send_frame(8'hA5, 1'b1, BIT_T);
      settle(10);
      chk("b2b_count", rcv_cnt, r0 + 3);
      chk("b2b_0", {24'h0, got[n0]},     32'h00);
      chk("b2b_1", {24'h0, got[n0 + 1]}, 32'hFF);
      chk("b2b_2", {24'h0, got[n0 + 2]}, 32'hA5);

      // reset pulse during bit 4 (line high from bit 4 onwards)
      r0 = rcv_cnt;
      f0 = ferr_cnt;
      fork
         send_frame(8'hF0, 1'b1, BIT_T);
         begin
            #(5 * BIT_T + 60);
            @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
         end
      join
      settle(20);
      chk("mid_rst_rcv",  rcv_cnt,  r0);
      chk("mid_rst_ferr", ferr_cnt, f0);
      chk("mid_rst_data", {24'h0, bus.data}, 32'h00);
      chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
      send_frame(8'h3C, 1'b1, BIT_T);
      settle(10);
      chk("post_rst_count", rcv_cnt, r0 + 1);
      chk("post_rst_data",  {24'h0, bus.data}, 32'h3C);

      // +/-3% bit-rate error
      r0 = rcv_cnt;
      f0 = ferr_cnt;
      send_frame(8'h96, 1'b1, 155);
      settle(20);
      chk("fast_count", rcv_cnt, r0 + 1);
      chk("fast_data",  {24'h0, bus.data}, 32'h96);
      chk("fast_ferr",  ferr_cnt, f0);
      send_frame(8'h96, 1'b1, 165);
      settle(20);
      chk("slow_count", rcv_cnt, r0 + 2);
      chk("slow_data",  {24'h0, got[got.size() - 1]}, 32'h96);
      chk("slow_ferr",  ferr_cnt, f0);

      // strobe exclusivity and single-cycle width over the whole run
      chk("strobe_rules", rule_viol, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
